collateral_sync_fifo: RTL and testbench

//  Single-clock FIFO that buffers SIZE-bit words between Theia pipeline units
//  (e.g. ahead of the opcode/operand registers and up-counters of the fetch path).

---
 rtl/collateral_sync_fifo_if.sv | 41 ++++
 rtl/collateral_sync_fifo.sv | 77 +++++++
 tb/tb_collateral_sync_fifo.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/collateral_sync_fifo_if.sv
// Handshake bundle for collateral_sync_fifo.
// AlmostFull exists only when FIFO_ALMOST_FULL_EN is defined.
interface collateral_sync_fifo_if #(
    parameter int SIZE       = 32,
    parameter int DEPTH_LOG2 = 3
);
    logic                  Write;
    logic [SIZE-1:0]       DataIn;
    logic                  Read;
    logic [SIZE-1:0]       DataOut;
    logic                  Empty;
    logic                  Full;
    logic [DEPTH_LOG2:0]   Count;
    logic                  Overflow;
    logic                  Underflow;
`ifdef FIFO_ALMOST_FULL_EN
    logic                  AlmostFull;

    modport master (
        output Write, DataIn, Read,
        input  DataOut, Empty, Full, Count,
        input  Overflow, Underflow, AlmostFull
    );
    modport slave (
        input  Write, DataIn, Read,
        output DataOut, Empty, Full, Count,
        output Overflow, Underflow, AlmostFull
    );
`else
    modport master (
        output Write, DataIn, Read,
        input  DataOut, Empty, Full, Count,
        input  Overflow, Underflow
    );
    modport slave (
        input  Write, DataIn, Read,
        output DataOut, Empty, Full, Count,
        output Overflow, Underflow
    );
`endif
endinterface

// File: rtl/collateral_sync_fifo.sv
// Single-clock first-word-fall-through FIFO with sticky overflow/underflow.
// Optional AlmostFull output enabled by defining FIFO_ALMOST_FULL_EN.
module collateral_sync_fifo #(
    parameter int SIZE       = 32,
    parameter int DEPTH_LOG2 = 3,
    parameter int AF_LEVEL   = 6
) (
    input logic                  Clock,
    input logic                  Reset,
    collateral_sync_fifo_if.slave bus
);
    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam int CW    = DEPTH_LOG2 + 1;

    if (AF_LEVEL < 1 || AF_LEVEL > DEPTH) begin : g_af_chk
        $error("AF_LEVEL out of range");
    end

    logic [SIZE-1:0]       mem [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr;
    logic [DEPTH_LOG2-1:0] rd_ptr;
    logic [CW-1:0]         count;
    logic [CW-1:0]         count_nxt;
    logic                  empty;
    logic                  full;
    logic                  ovf;
    logic                  unf;
    logic                  push_ok;
    logic                  pop_ok;

    assign push_ok   = bus.Write & ~full;
    assign pop_ok    = bus.Read & ~empty;
    assign count_nxt = count + CW'(push_ok) - CW'(pop_ok);

    always_ff @(posedge Clock) begin
        if (Reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            empty  <= 1'b1;
            full   <= 1'b0;
            ovf    <= 1'b0;
            unf    <= 1'b0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
            count <= count_nxt;
            empty <= (count_nxt == '0);
            full  <= (count_nxt == CW'(DEPTH));
            if (bus.Write & full)  ovf <= 1'b1;
            if (bus.Read  & empty) unf <= 1'b1;
        end
    end

    // Storage is deliberately left uncleared by reset.
    always_ff @(posedge Clock) begin
        if (!Reset && push_ok) mem[wr_ptr] <= bus.DataIn;
    end

    assign bus.DataOut   = mem[rd_ptr];
    assign bus.Empty     = empty;
    assign bus.Full      = full;
    assign bus.Count     = count;
    assign bus.Overflow  = ovf;
    assign bus.Underflow = unf;

`ifdef FIFO_ALMOST_FULL_EN
    logic afull;

    always_ff @(posedge Clock) begin
        if (Reset) afull <= 1'b0;
        else       afull <= (count_nxt >= CW'(AF_LEVEL));
    end

    assign bus.AlmostFull = afull;
`endif
endmodule

// File: tb/tb_collateral_sync_fifo.sv
// Directed self-checking bench for collateral_sync_fifo (DEPTH=4).
// Inputs change 1 time unit after posedge; outputs sampled there too.
module tb_collateral_sync_fifo;
    localparam int SIZE = 32;
    localparam int DL2  = 2;
    localparam int AFL  = 3;

    logic Clock = 1'b0;
    logic Reset;
    int   checks = 0;
    int   errors = 0;

    collateral_sync_fifo_if #(.SIZE(SIZE), .DEPTH_LOG2(DL2)) bus ();

    collateral_sync_fifo #(
        .SIZE(SIZE), .DEPTH_LOG2(DL2), .AF_LEVEL(AFL)
    ) dut (
        .Clock(Clock),
        .Reset(Reset),
        .bus  (bus)
    );

    always #5 Clock = ~Clock;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    task automatic drive(input logic w, input logic r,
                         input logic [31:0] d);
        bus.Write  = w;
        bus.Read   = r;
        bus.DataIn = d;
    endtask

    initial begin
        Reset = 1'b1;
        drive(1'b0, 1'b0, 32'h0);
        tick();
        tick();
        Reset = 1'b0;
        repeat (3) tick();
        chk("rst_empty", 32'(bus.Empty), 32'd1);
        chk("rst_full",  32'(bus.Full), 32'd0);
        chk("rst_count", 32'(bus.Count), 32'd0);
        chk("rst_ovf",   32'(bus.Overflow), 32'd0);
        chk("rst_unf",   32'(bus.Underflow), 32'd0);
`ifdef FIFO_ALMOST_FULL_EN
        chk("rst_af",    32'(bus.AlmostFull), 32'd0);
`endif

        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 1'b0, 32'hA0 + 32'(i));
            tick();
            chk("fill_count", 32'(bus.Count), 32'(i + 1));
            chk("fill_head",  bus.DataOut, 32'hA0);
            chk("fill_empty", 32'(bus.Empty), 32'd0);
            chk("fill_full",  32'(bus.Full), (i == 3) ? 32'd1 : 32'd0);
`ifdef FIFO_ALMOST_FULL_EN
            chk("fill_af", 32'(bus.AlmostFull), (i >= 2) ? 32'd1 : 32'd0);
`endif
        end

        drive(1'b1, 1'b0, 32'hFF);
        tick();
        drive(1'b0, 1'b0, 32'h0);
        chk("ovf_flag",  32'(bus.Overflow), 32'd1);
        chk("ovf_count", 32'(bus.Count), 32'd4);
        chk("ovf_head",  bus.DataOut, 32'hA0);
        for (int i = 0; i < 4; i++) begin
            chk("pop_data", bus.DataOut, 32'hA0 + 32'(i));
            drive(1'b0, 1'b1, 32'h0);
            tick();
            chk("pop_count", 32'(bus.Count), 32'(3 - i));
        end
        drive(1'b0, 1'b0, 32'h0);
        chk("drain_empty", 32'(bus.Empty), 32'd1);
        chk("drain_unf",   32'(bus.Underflow), 32'd0);
        chk("drain_ovf",   32'(bus.Overflow), 32'd1);

        drive(1'b1, 1'b1, 32'h55);
        tick();
        drive(1'b0, 1'b0, 32'h0);
        chk("wr_rd_empty_count", 32'(bus.Count), 32'd1);
        chk("wr_rd_empty_unf",   32'(bus.Underflow), 32'd1);
        chk("wr_rd_empty_head",  bus.DataOut, 32'h55);
        chk("wr_rd_empty_empty", 32'(bus.Empty), 32'd0);

        drive(1'b1, 1'b0, 32'h60);
        tick();
        chk("pre_stream_count", 32'(bus.Count), 32'd2);
        for (int k = 0; k < 10; k++) begin
            chk("stream_head", bus.DataOut,
                (k == 0) ? 32'h55 : 32'h60 + 32'(k - 1));
            drive(1'b1, 1'b1, 32'h61 + 32'(k));
            tick();
            chk("stream_count", 32'(bus.Count), 32'd2);
        end
        drive(1'b0, 1'b0, 32'h0);
        chk("stream_tail_head", bus.DataOut, 32'h69);

        drive(1'b1, 1'b0, 32'h70);
        tick();
        chk("pre_rst_count", 32'(bus.Count), 32'd3);
        Reset = 1'b1;
        drive(1'b1, 1'b0, 32'h77);
        tick();
        Reset = 1'b0;
        drive(1'b0, 1'b0, 32'h0);
        chk("mid_rst_count", 32'(bus.Count), 32'd0);
        chk("mid_rst_empty", 32'(bus.Empty), 32'd1);
        chk("mid_rst_full",  32'(bus.Full), 32'd0);
        chk("mid_rst_ovf",   32'(bus.Overflow), 32'd0);
        chk("mid_rst_unf",   32'(bus.Underflow), 32'd0);
`ifdef FIFO_ALMOST_FULL_EN
        chk("mid_rst_af",    32'(bus.AlmostFull), 32'd0);
`endif

        drive(1'b1, 1'b0, 32'h88);
        tick();
        drive(1'b0, 1'b0, 32'h0);
        chk("post_rst_count", 32'(bus.Count), 32'd1);
        chk("post_rst_head",  bus.DataOut, 32'h88);

        drive(1'b0, 1'b1, 32'h0);
        tick();
        drive(1'b0, 1'b1, 32'h0);
        tick();
        drive(1'b0, 1'b0, 32'h0);
        chk("final_empty", 32'(bus.Empty), 32'd1);
        chk("final_count", 32'(bus.Count), 32'd0);
        chk("final_unf",   32'(bus.Underflow), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
